dm_sba_gen: RTL and testbench
=============================

Name: dm_sba_gen

Overview:
- Parametrised system bus access engine for the debug module. It turns debugger SBA requests (sbaddress/sbdata CSR accesses) into single-beat transactions on a req/gnt/r_valid memory-style master port.
- Compared with the first-generation SBA, it adds:
  - independent address and data widths, with accesses up to 128 bits;
  - write-lane placement and read-data alignment;
  - bus-error and timeout reporting;
  - misalignment and size checks;
  - busy-error detection.

Parameters:
- AddrWidth, 32, width of sbaddress and master address.
- BusWidth, 32, data bus width; legal values 32, 64, 128.
- ReadByteEnable, 1, drive computed byte enables on reads (0: reads use be='0).
- TimeoutCycles, 0, cycles in a non-Idle state before a timeout abort; 0 disables.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active low
- dmactive_i  in  1  sync reset, active low
- master_req_o  out  1  bus request
- master_add_o  out  AddrWidth  byte address (= sbaddress_i, unmodified)
- master_we_o  out  1  write enable
- master_wdata_o  out  BusWidth  write data, lane-shifted
- master_be_o  out  BusWidth/8  byte enables
- master_gnt_i  in  1  grant
- master_r_valid_i  in  1  response valid (reads and writes)
- master_r_err_i  in  1  response error, qualified by r_valid
- master_r_rdata_i  in  BusWidth  read data
- sbaddress_i  in  AddrWidth  current sbaddress CSR
- sbaddress_write_valid_i  in  1  sbaddress written
- sbreadonaddr_i  in  1  read on address write
- sbautoincrement_i  in  1  increment address after a successful access
- sbaccess_i  in  3  log2 of access size in bytes
- sbreadondata_i  in  1  read on sbdata read
- sbdata_i  in  BusWidth  write data (LSB-aligned)
- sbdata_read_valid_i  in  1  sbdata read by debugger
- sbdata_write_valid_i  in  1  sbdata written
- sbaddress_o  out  AddrWidth  next address value for the CSR
- sbdata_o  out  BusWidth  LSB-aligned read data
- sbdata_valid_o  out  1  read data valid
- sbbusy_o  out  1  engine busy
- sbbusyerror_o  out  1  pulse: request dropped while busy
- sberror_valid_o  out  1  pulse: error code valid
- sberror_o  out  3  error code

Behaviour:
- Reset and defaults:
  - Reset (rst_ni=0 or dmactive_i=0) puts the FSM in Idle and clears the timeout counter.
  - All outputs default to 0, except sbaddress_o=sbaddress_i.
  - dmactive_i=0 mid-transaction aborts the transaction immediately. A late r_valid is then ignored in Idle.
- States: Idle, Read, Write, WaitRead, WaitWrite. sbbusy_o = (state != Idle).
- Request decode in Idle:
  - Write request: sbdata_write_valid_i.
  - Read requests: sbaddress_write_valid_i&&sbreadonaddr_i, or sbdata_read_valid_i&&sbreadondata_i.
  - A write has priority over a read in the same cycle; the read is dropped silently.
- Launch checks in Idle, evaluated in order, each a 1-cycle sberror pulse with the FSM staying in Idle:
  - (1<<sbaccess_i) > BusWidth/8, or sbaccess_i>4 → code 4.
  - sbaddress_i not aligned to 2^sbaccess_i → code 3.
  - Otherwise → Read or Write.
- Read/Write states:
  - Hold master_req_o=1 until master_gnt_i; gnt in cycle N means Wait* is entered at N+1.
  - Req may not drop before gnt.
- Wait states: on master_r_valid_i, go to Idle.
  - r_err=1: sberror_valid_o=1, sberror_o=2, no increment, sbdata_valid_o=0.
  - Otherwise, WaitRead raises sbdata_valid_o for that cycle.
  - Otherwise, with sbautoincrement_i set, sbaddress_o = sbaddress_i + (1<<sbaccess_i), modulo 2^AddrWidth (wraps to 0).
- Byte enables and data placement, with off = sbaddress_i[log2(BusWidth/8)-1:0]:
  - be = ((1<<(1<<sbaccess_i))-1) << off.
  - wdata = sbdata_i << (8*off).
  - sbdata_o = rdata >> (8*off).
  - sbaddress_i is stable while busy.
- Timeout (TimeoutCycles>0):
  - The counter resets on entering Read/Write and counts every non-Idle cycle.
  - When it reaches TimeoutCycles without completion: go to Idle, req=0, sberror code 1. A later r_valid is ignored.
  - Timeout takes priority over an r_valid in the same cycle.
- Busy error: any qualifying request while state != Idle pulses sbbusyerror_o for 1 cycle. The request is dropped and the current transaction continues.
- The engine never has more than one outstanding transaction.

Test Plan:
- Read, BusWidth=64, addr=0x1004, sbaccess=2, gnt 2 cycles late, rdata=0xAABBCCDD_11223344:
  - req held 3 cycles, be=0xF0;
  - sbdata_o[31:0]=0xAABBCCDD, sbdata_valid_o 1 cycle;
  - autoinc → sbaddress_o=0x1008.
- Write, BusWidth=128, addr=0x1E, sbaccess=1, sbdata=0xBEEF:
  - be=0xC000, wdata[127:112]=0xBEEF.
- Launch errors:
  - sbaccess=4 on BusWidth=32 → code 4, no req.
  - addr=0x3, sbaccess=2 → code 3, no req.
- Bus error: r_valid with r_err=1 on a read → code 2, sbdata_valid_o=0, sbaddress_o unchanged.
- Timeout, TimeoutCycles=8, gnt never asserted:
  - code 1 after 8 busy cycles, FSM in Idle;
  - a request during the busy window pulses sbbusyerror_o.
- Reset and wrap:
  - dmactive_i=0 in WaitWrite → Idle next cycle.
  - Autoinc from 0xFFFFFFFC (sbaccess=2) → 0x0.

Source files
------------

// File: rtl/dm_sba_gen.sv
`default_nettype none
// ============================================================================
// Module   : dm_sba_gen
// Purpose  : System bus access engine for the debug module. It turns debugger
//            SBA requests (sbaddress / sbdata CSR accesses) into single-beat
//            transactions on a req/gnt/r_valid memory-style master port.
//            Supports separate address and data widths, accesses up to 128 bits,
//            byte-lane placement of write data, alignment of read data, bus
//            error and timeout reporting, launch-time size and alignment
//            checks, and busy-error detection.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   dmactive_i                 synchronous active-low reset / abort
//   master_req_o..master_be_o  request side of the bus master port
//   master_gnt_i               request accepted by the bus
//   master_r_valid_i/_err_i    response (reads and writes) and its error flag
//   master_r_rdata_i           read data, still in bus-lane position
//   sbaddress_i, sbaccess_i    current address and log2 access size
//   sbreadonaddr_i             an address write also starts a read
//   sbreadondata_i             an sbdata read also starts a read
//   sbautoincrement_i          advance the address after a good access
//   sbdata_i                   write data, LSB-aligned
//   sb*_valid_i                CSR access strobes from the debugger
//   sbaddress_o                next sbaddress value (pass-through or +size)
//   sbdata_o, sbdata_valid_o   LSB-aligned read data and its strobe
//   sbbusy_o                   a transaction is in flight
//   sbbusyerror_o              a request was dropped because we were busy
//   sberror_valid_o, sberror_o error code pulse
//                              (1 timeout, 2 bus error, 3 misaligned, 4 size)
// ============================================================================
module dm_sba_gen #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned BusWidth       = 32,
    parameter bit          ReadByteEnable = 1'b1,
    parameter int unsigned TimeoutCycles  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,

    output logic                  master_req_o,
    output logic [AddrWidth-1:0]  master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,

    input  logic [AddrWidth-1:0]  sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,

    output logic [AddrWidth-1:0]  sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sbbusyerror_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o
);

    localparam int unsigned BeWidth   = BusWidth / 8;
    localparam int unsigned OffWidth  = $clog2(BeWidth);
    localparam bit          TimeoutEn = (TimeoutCycles > 0);
    // Counter value seen in the last permitted busy cycle.
    localparam logic [31:0] TimeoutLast = TimeoutEn ? 32'(TimeoutCycles - 1) : 32'd0;

    localparam logic [2:0] ErrTimeout  = 3'd1;
    localparam logic [2:0] ErrBus      = 3'd2;
    localparam logic [2:0] ErrAlign    = 3'd3;
    localparam logic [2:0] ErrSize     = 3'd4;

    typedef enum logic [2:0] {
        Idle      = 3'd0,
        Read      = 3'd1,
        Write     = 3'd2,
        WaitRead  = 3'd3,
        WaitWrite = 3'd4
    } state_e;

    state_e      state_d, state_q;
    logic [31:0] cnt_d, cnt_q;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic wr_req, rd_req, any_req, busy;

    assign wr_req  = sbdata_write_valid_i;
    assign rd_req  = (sbaddress_write_valid_i & sbreadonaddr_i)
                   | (sbdata_read_valid_i & sbreadondata_i);
    assign any_req = wr_req | rd_req;
    assign busy    = (state_q != Idle);

    // ------------------------------------------------------------------------
    // Lane placement. The byte offset inside a bus word selects the lanes for
    // both directions; sbaddress_i is held stable by the CSR logic while busy.
    // ------------------------------------------------------------------------
    logic [OffWidth-1:0]  off;
    logic [OffWidth+2:0]  bit_off;
    logic [15:0]          be_base;
    logic [BeWidth-1:0]   be_lanes;
    logic [BusWidth-1:0]  wdata_lanes;
    logic [BusWidth-1:0]  rdata_aligned;

    assign off     = sbaddress_i[OffWidth-1:0];
    assign bit_off = {off, 3'b000};

    always_comb begin
        be_base = 16'h0000;
        case (sbaccess_i)
            3'd0:    be_base = 16'h0001;
            3'd1:    be_base = 16'h0003;
            3'd2:    be_base = 16'h000F;
            3'd3:    be_base = 16'h00FF;
            3'd4:    be_base = 16'hFFFF;
            default: be_base = 16'h0000;
        endcase
    end

    // Sizes wider than the bus never launch, so truncating the mask is safe.
    assign be_lanes      = BeWidth'(be_base) << off;
    assign wdata_lanes   = sbdata_i << bit_off;
    assign rdata_aligned = master_r_rdata_i >> bit_off;

    // ------------------------------------------------------------------------
    // Launch checks and address increment
    // ------------------------------------------------------------------------
    logic                 size_err, align_err;
    logic [AddrWidth-1:0] size_bytes;
    logic [AddrWidth-1:0] align_mask;
    logic [AddrWidth-1:0] incr_addr;

    // The bus is 2^OffWidth bytes wide, and OffWidth never exceeds 4, so this
    // single compare covers both "too wide for the bus" and "above 128 bits".
    assign size_err   = (sbaccess_i > 3'(OffWidth));
    assign size_bytes = AddrWidth'(1) << sbaccess_i;
    assign align_mask = size_bytes - AddrWidth'(1);
    assign align_err  = |(sbaddress_i & align_mask);
    // Natural modulo-2^AddrWidth wrap of the adder gives the required rollover.
    assign incr_addr  = sbaddress_i + size_bytes;

    // ------------------------------------------------------------------------
    // Timeout detect: the counter holds 0 in the first busy cycle, so it sits
    // at TimeoutCycles-1 in the last busy cycle that is allowed to complete.
    // ------------------------------------------------------------------------
    logic timeout;
    assign timeout = TimeoutEn && busy && (cnt_q == TimeoutLast);

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        master_req_o    = 1'b0;
        master_add_o    = '0;
        master_we_o     = 1'b0;
        master_wdata_o  = '0;
        master_be_o     = '0;
        sbaddress_o     = sbaddress_i;
        sbdata_o        = '0;
        sbdata_valid_o  = 1'b0;
        sbbusy_o        = 1'b0;
        sbbusyerror_o   = 1'b0;
        sberror_valid_o = 1'b0;
        sberror_o       = 3'd0;

        if (!dmactive_i) begin
            // Abort whatever is in flight; any late response lands in Idle.
            state_d = Idle;
            cnt_d   = '0;
        end else begin
            sbbusy_o = busy;

            if (busy) begin
                cnt_d         = cnt_q + 32'd1;
                sbbusyerror_o = any_req;
            end

            if (timeout) begin
                // Beats a response arriving in the same cycle.
                state_d         = Idle;
                cnt_d           = '0;
                sberror_valid_o = 1'b1;
                sberror_o       = ErrTimeout;
            end else begin
                case (state_q)
                    Idle: begin
                        if (any_req) begin
                            if (size_err) begin
                                sberror_valid_o = 1'b1;
                                sberror_o       = ErrSize;
                            end else if (align_err) begin
                                sberror_valid_o = 1'b1;
                                sberror_o       = ErrAlign;
                            end else begin
                                // A write wins; a simultaneous read is dropped.
                                state_d = wr_req ? Write : Read;
                                cnt_d   = '0;
                            end
                        end
                    end

                    Read: begin
                        master_req_o = 1'b1;
                        master_add_o = sbaddress_i;
                        master_be_o  = ReadByteEnable ? be_lanes : '0;
                        if (master_gnt_i) begin
                            state_d = WaitRead;
                        end
                    end

                    Write: begin
                        master_req_o   = 1'b1;
                        master_add_o   = sbaddress_i;
                        master_we_o    = 1'b1;
                        master_wdata_o = wdata_lanes;
                        master_be_o    = be_lanes;
                        if (master_gnt_i) begin
                            state_d = WaitWrite;
                        end
                    end

                    WaitRead, WaitWrite: begin
                        if (master_r_valid_i) begin
                            state_d = Idle;
                            if (master_r_err_i) begin
                                sberror_valid_o = 1'b1;
                                sberror_o       = ErrBus;
                            end else begin
                                if (state_q == WaitRead) begin
                                    sbdata_valid_o = 1'b1;
                                    sbdata_o       = rdata_aligned;
                                end
                                if (sbautoincrement_i) begin
                                    sbaddress_o = incr_addr;
                                end
                            end
                        end
                    end

                    default: begin
                        state_d = Idle;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_sba_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_sba_gen
// Purpose  : Self-checking bench for dm_sba_gen (64-bit bus, 8-cycle timeout).
//            Directed cases followed by randomized transactions; expected
//            values come from per-cycle arithmetic on the transaction's
//            parameters (size, offset, grant/response delays).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_sba_gen;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 64;
    localparam int unsigned TO = 8;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           dmactive_i;
    logic           master_req_o;
    logic [AW-1:0]  master_add_o;
    logic           master_we_o;
    logic [BW-1:0]  master_wdata_o;
    logic [BW/8-1:0] master_be_o;
    logic           master_gnt_i;
    logic           master_r_valid_i;
    logic           master_r_err_i;
    logic [BW-1:0]  master_r_rdata_i;
    logic [AW-1:0]  sbaddress_i;
    logic           sbaddress_write_valid_i;
    logic           sbreadonaddr_i;
    logic           sbautoincrement_i;
    logic [2:0]     sbaccess_i;
    logic           sbreadondata_i;
    logic [BW-1:0]  sbdata_i;
    logic           sbdata_read_valid_i;
    logic           sbdata_write_valid_i;
    logic [AW-1:0]  sbaddress_o;
    logic [BW-1:0]  sbdata_o;
    logic           sbdata_valid_o;
    logic           sbbusy_o;
    logic           sbbusyerror_o;
    logic           sberror_valid_o;
    logic [2:0]     sberror_o;

    int checks = 0;
    int errors = 0;

    dm_sba_gen #(
        .AddrWidth      (AW),
        .BusWidth       (BW),
        .ReadByteEnable (1'b1),
        .TimeoutCycles  (TO)
    ) u_dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .dmactive_i              (dmactive_i),
        .master_req_o            (master_req_o),
        .master_add_o            (master_add_o),
        .master_we_o             (master_we_o),
        .master_wdata_o          (master_wdata_o),
        .master_be_o             (master_be_o),
        .master_gnt_i            (master_gnt_i),
        .master_r_valid_i        (master_r_valid_i),
        .master_r_err_i          (master_r_err_i),
        .master_r_rdata_i        (master_r_rdata_i),
        .sbaddress_i             (sbaddress_i),
        .sbaddress_write_valid_i (sbaddress_write_valid_i),
        .sbreadonaddr_i          (sbreadonaddr_i),
        .sbautoincrement_i       (sbautoincrement_i),
        .sbaccess_i              (sbaccess_i),
        .sbreadondata_i          (sbreadondata_i),
        .sbdata_i                (sbdata_i),
        .sbdata_read_valid_i     (sbdata_read_valid_i),
        .sbdata_write_valid_i    (sbdata_write_valid_i),
        .sbaddress_o             (sbaddress_o),
        .sbdata_o                (sbdata_o),
        .sbdata_valid_o          (sbdata_valid_o),
        .sbbusy_o                (sbbusy_o),
        .sbbusyerror_o           (sbbusyerror_o),
        .sberror_valid_o         (sberror_valid_o),
        .sberror_o               (sberror_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_pulses();
        sbdata_write_valid_i    = 1'b0;
        sbaddress_write_valid_i = 1'b0;
        sbreadonaddr_i          = 1'b0;
        sbdata_read_valid_i     = 1'b0;
        sbreadondata_i          = 1'b0;
        master_gnt_i            = 1'b0;
        master_r_valid_i        = 1'b0;
        master_r_err_i          = 1'b0;
        master_r_rdata_i        = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled one
    // unit later, well away from the next edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        clr_pulses();
    endtask

    // One complete debugger request. gdly: cycles of req before gnt arrives
    // (gnt in busy cycle gdly+1); rdly: idle wait cycles before r_valid.
    // berr_cyc: busy cycle in which an extra request is injected (0 = none).
    task automatic run_txn(input bit is_wr, input bit also_rd, input bit rd_on_data,
                           input logic [31:0] addr, input logic [2:0] acc,
                           input logic [63:0] wd, input bit ainc,
                           input int gdly, input int rdly, input bit rerr,
                           input logic [63:0] rd, input int berr_cyc);
        int          nbytes, exp_code, total, offs;
        bit          in_req, tmo, timed_out;
        logic [31:0] be_wide;
        logic [63:0] exp_wd, exp_rd;
        logic [31:0] exp_addr;

        next_cycle();
        sbaddress_i       = addr;
        sbaccess_i        = acc;
        sbautoincrement_i = ainc;
        sbdata_i          = wd;
        if (is_wr) sbdata_write_valid_i = 1'b1;
        if (!is_wr || also_rd) begin
            if (rd_on_data) begin
                sbdata_read_valid_i = 1'b1;
                sbreadondata_i      = 1'b1;
            end else begin
                sbaddress_write_valid_i = 1'b1;
                sbreadonaddr_i          = 1'b1;
            end
        end
        #1;

        nbytes   = 1 << acc;
        if (acc > 3'd4 || nbytes > BW / 8)      exp_code = 4;
        else if ((addr % nbytes) != 0)          exp_code = 3;
        else                                    exp_code = 0;

        check("launch_busy", sbbusy_o, 1'b0);
        check("launch_req", master_req_o, 1'b0);
        check("launch_errv", sberror_valid_o, exp_code != 0);
        if (exp_code != 0) begin
            check("launch_code", sberror_o, exp_code[2:0]);
            next_cycle();
            #1;
            check("launch_err_stays_idle", sbbusy_o, 1'b0);
            check("launch_err_no_req", master_req_o, 1'b0);
            return;
        end

        offs     = int'(addr % (BW / 8));
        be_wide  = ((32'd1 << nbytes) - 32'd1) << offs;
        exp_wd   = wd << (8 * offs);
        exp_rd   = rd >> (8 * offs);
        exp_addr = (ainc && !rerr) ? addr + 32'(nbytes) : addr;
        total    = (gdly + 1) + (rdly + 1);
        timed_out = (total > TO);

        for (int b = 1; b <= total && b <= TO; b++) begin
            next_cycle();
            in_req = (b <= gdly + 1);
            tmo    = (b == TO);
            if (b == berr_cyc) begin
                sbdata_read_valid_i = 1'b1;
                sbreadondata_i      = 1'b1;
            end
            if (in_req && b == gdly + 1) master_gnt_i = 1'b1;
            if (!in_req && b == total) begin
                master_r_valid_i = 1'b1;
                master_r_err_i   = rerr;
                master_r_rdata_i = rd;
            end
            #1;
            check("busy", sbbusy_o, 1'b1);
            check("busyerror", sbbusyerror_o, b == berr_cyc);
            check("req", master_req_o, in_req && !tmo);
            if (in_req && !tmo) begin
                check("addr", master_add_o, addr);
                check("we", master_we_o, is_wr);
                check("be", master_be_o, be_wide[7:0]);
                if (is_wr) check("wdata", master_wdata_o, exp_wd);
            end
            if (tmo) begin
                check("timeout_errv", sberror_valid_o, 1'b1);
                check("timeout_code", sberror_o, 3'd1);
                check("timeout_no_data", sbdata_valid_o, 1'b0);
            end else if (b == total) begin
                check("resp_errv", sberror_valid_o, rerr);
                if (rerr) check("resp_code", sberror_o, 3'd2);
                check("rdata_valid", sbdata_valid_o, !is_wr && !rerr);
                if (!is_wr && !rerr) check("rdata", sbdata_o, exp_rd);
                check("next_addr", sbaddress_o, exp_addr);
            end else begin
                check("mid_errv", sberror_valid_o, 1'b0);
                check("mid_valid", sbdata_valid_o, 1'b0);
            end
        end

        // Back in Idle; after a timeout a straggling response must be ignored.
        next_cycle();
        if (timed_out) begin
            master_r_valid_i = 1'b1;
            master_r_rdata_i = rd;
        end
        #1;
        check("after_idle", sbbusy_o, 1'b0);
        check("after_no_valid", sbdata_valid_o, 1'b0);
        check("after_no_err", sberror_valid_o, 1'b0);
        check("after_addr_pass", sbaddress_o, addr);
    endtask

    logic [31:0] r_addr;
    logic [2:0]  r_acc;
    bit          r_wr, r_also, r_kind, r_err, r_inc;
    int          r_g, r_r, r_b;

    initial begin
        rst_ni            = 1'b0;
        dmactive_i        = 1'b1;
        sbaddress_i       = 32'h0000_1234;
        sbaccess_i        = 3'd2;
        sbautoincrement_i = 1'b0;
        sbdata_i          = '0;
        clr_pulses();
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_busy", sbbusy_o, 1'b0);
        check("reset_req", master_req_o, 1'b0);
        check("reset_addr_pass", sbaddress_o, 32'h0000_1234);
        rst_ni = 1'b1;

        // Read, 64-bit bus, gnt two cycles late, upper word selected.
        run_txn(0, 0, 0, 32'h0000_1004, 3'd2, 64'h0, 1, 2, 1, 0,
                64'hAABB_CCDD_1122_3344, 0);
        // Halfword write in the top lanes.
        run_txn(1, 0, 0, 32'h0000_001E, 3'd1, 64'hBEEF, 0, 0, 0, 0, 64'h0, 0);
        // Size errors: 128-bit on a 64-bit bus, and an out-of-range code.
        run_txn(0, 0, 1, 32'h0000_0000, 3'd4, 64'h0, 0, 0, 0, 0, 64'h0, 0);
        run_txn(1, 0, 0, 32'h0000_0000, 3'd7, 64'h0, 0, 0, 0, 0, 64'h0, 0);
        // Misaligned word.
        run_txn(0, 0, 0, 32'h0000_0003, 3'd2, 64'h0, 0, 0, 0, 0, 64'h0, 0);
        // Bus error on a read: no data, no increment.
        run_txn(0, 0, 1, 32'h0000_0100, 3'd3, 64'h0, 1, 1, 2, 1, 64'h1234, 0);
        // Timeout with gnt never given, plus a busy-error request.
        run_txn(0, 0, 0, 32'h0000_2000, 3'd2, 64'h0, 1, 50, 0, 0, 64'h0, 3);
        // Timeout while waiting for the response of a write.
        run_txn(1, 0, 0, 32'h0000_2008, 3'd3, 64'h55, 1, 1, 20, 0, 64'h0, 0);
        // Address wrap on auto-increment.
        run_txn(0, 0, 0, 32'hFFFF_FFFC, 3'd2, 64'h0, 1, 0, 0, 0,
                64'h0102_0304_0506_0708, 0);
        // Write and read request together: the write wins.
        run_txn(1, 1, 0, 32'h0000_0040, 3'd0, 64'h5A, 1, 1, 1, 0, 64'h0, 2);

        // dmactive drop while in WaitWrite.
        next_cycle();
        sbaddress_i          = 32'h0000_0080;
        sbaccess_i           = 3'd3;
        sbdata_i             = 64'h1111_2222_3333_4444;
        sbdata_write_valid_i = 1'b1;
        next_cycle();
        master_gnt_i = 1'b1;
        #1;
        check("dm_write_req", master_req_o, 1'b1);
        next_cycle();
        dmactive_i = 1'b0;
        next_cycle();
        dmactive_i = 1'b1;
        #1;
        check("dm_abort_idle", sbbusy_o, 1'b0);
        check("dm_abort_no_req", master_req_o, 1'b0);
        next_cycle();
        master_r_valid_i = 1'b1;
        master_r_err_i   = 1'b1;
        #1;
        check("dm_late_rvalid_no_err", sberror_valid_o, 1'b0);
        check("dm_late_rvalid_busy", sbbusy_o, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 200; n++) begin
            r_acc = 3'($urandom_range(0, 3));
            if ($urandom % 10 == 0) r_acc = 3'($urandom_range(4, 7));
            r_addr = $urandom;
            if ($urandom % 6 == 0) r_addr = 32'hFFFF_FFF0 | (r_addr & 32'hF);
            if ($urandom % 5 != 0) r_addr = r_addr & ~((32'd1 << r_acc) - 32'd1);
            r_wr   = ($urandom % 2) == 1;
            r_also = r_wr && ($urandom % 4 == 0);
            r_kind = ($urandom % 2) == 1;
            r_err  = ($urandom % 6 == 0);
            r_inc  = ($urandom % 2) == 1;
            r_g    = $urandom_range(0, 4);
            r_r    = $urandom_range(0, 3);
            r_b    = ($urandom % 3 == 0) ? $urandom_range(1, 5) : 0;
            run_txn(r_wr, r_also, r_kind, r_addr, r_acc,
                    {$urandom, $urandom}, r_inc, r_g, r_r, r_err,
                    {$urandom, $urandom}, r_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
